riscv_data_mem_responder: RTL and testbench

- Memory-side responder for the core's data request/grant/rvalid interface: a single-port tightly-coupled data RAM that grants LSU requests, commits byte-enabled stores and returns load data.
- Used as the data TCM and as the reference slave in core-level benches.
- Supports at most one outstanding transaction, a fixed response latency, injectable grant back-pressure, and an address-range error.

---
 rtl/riscv_data_mem_responder_if.sv | 23 ++
 rtl/riscv_data_mem_responder.sv | 87 ++++++++
 tb/tb_riscv_data_mem_responder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_data_mem_responder_if.sv
// Data-side request/grant/rvalid bus between an LSU (master) and a memory responder (slave).
// Handshake: a request is accepted only in a cycle where data_req_i and data_gnt_o are both 1; exactly one data_rvalid_o pulse follows each accepted request, and data_err_o is meaningful only in the grant cycle.
interface riscv_data_mem_responder_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_err_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
    );
endinterface

// File: rtl/riscv_data_mem_responder.sv
// Single-port data TCM responder: one outstanding transaction, fixed response latency,
// grant back-pressure hook and out-of-range error reporting.
module riscv_data_mem_responder #(
    parameter int          ADDR_WIDTH   = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0010_0000,
    parameter int          RESP_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    riscv_data_mem_responder_if.slave     bus,
    input  logic                          gnt_stall_i,
    output logic                          busy_o,
    output logic                          state_dbg,
    output logic [3:0]                    cnt_dbg
);
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    localparam int         HI     = ADDR_WIDTH + 2;
    localparam logic [3:0] LAT_M1 = 4'(RESP_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             rdata_q;
    logic [31:0]             mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    in_range;
    logic                    rvalid_now;
    logic                    gnt;
    logic                    unused_addr_lsb;

    assign idx             = bus.data_addr_i[HI-1:2];
    assign in_range        = (bus.data_addr_i[31:HI] == BASE_ADDR[31:HI]);
    assign unused_addr_lsb = ^bus.data_addr_i[1:0];

    // rvalid depends only on registered state, so a grant may coincide with it.
    assign rvalid_now = (state_q == PEND) && (cnt_q == 4'd0);
    assign gnt        = bus.data_req_i & ~gnt_stall_i & ~rst & ((state_q == IDLE) | rvalid_now);

    assign bus.data_gnt_o    = gnt;
    assign bus.data_err_o    = gnt & ~in_range;
    assign bus.data_rvalid_o = rvalid_now;
    assign bus.data_rdata_o  = rvalid_now ? rdata_q : 32'h0;

    assign busy_o    = (state_q == PEND);
    assign state_dbg = state_q;
    assign cnt_dbg   = cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (gnt) begin
            state_d = PEND;
            cnt_d   = LAT_M1;
        end else if (state_q == PEND) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (gnt) begin
                // Stores and out-of-range loads return zero data.
                rdata_q <= (!bus.data_we_i && in_range) ? mem[idx] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt && bus.data_we_i && in_range) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.data_be_i[n]) begin
                    mem[idx][8*n +: 8] <= bus.data_wdata_i[8*n +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// Directed bench for the data memory responder: one instance at latency 1, one at latency 3.
module tb_riscv_data_mem_responder;
    logic clk;
    logic rst;
    logic stall1, stall3;
    logic busy1, busy3;
    logic sd1, sd3;
    logic [3:0] cd1, cd3;
    int total;
    int bad;

    riscv_data_mem_responder_if bus1();
    riscv_data_mem_responder_if bus3();

    riscv_data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0010_0000), .RESP_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .gnt_stall_i(stall1),
        .busy_o(busy1), .state_dbg(sd1), .cnt_dbg(cd1)
    );

    riscv_data_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0010_0000), .RESP_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave), .gnt_stall_i(stall3),
        .busy_o(busy3), .state_dbg(sd3), .cnt_dbg(cd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata);
        bus1.data_req_i   = req;
        bus1.data_we_i    = we;
        bus1.data_addr_i  = addr;
        bus1.data_be_i    = be;
        bus1.data_wdata_i = wdata;
    endtask

    task automatic drv3(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata);
        bus3.data_req_i   = req;
        bus3.data_we_i    = we;
        bus3.data_addr_i  = addr;
        bus3.data_be_i    = be;
        bus3.data_wdata_i = wdata;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        stall1 = 1'b0;
        stall3 = 1'b0;
        drv1(1'b1, 1'b0, 32'h0010_0000, 4'hF, 32'h0);
        drv3(1'b0, 1'b0, 32'h0010_0000, 4'hF, 32'h0);

        // Reset: grant held off while rst is high even with a request present
        cyc();
        #1;
        chk("gnt_in_reset", 32'(bus1.data_gnt_o), 32'h0);
        cyc();
        rst = 1'b0;
        drv1(1'b0, 1'b0, 32'h0010_0000, 4'hF, 32'h0);
        #1;
        chk("rst_rvalid1", 32'(bus1.data_rvalid_o), 32'h0);
        chk("rst_rdata1", bus1.data_rdata_o, 32'h0);
        chk("rst_busy1", 32'(busy1), 32'h0);
        chk("rst_busy3", 32'(busy3), 32'h0);

        // Stall while idle: no grant, no state change
        stall1 = 1'b1;
        drv1(1'b1, 1'b1, 32'h0010_0010, 4'hF, 32'h0BAD_0BAD);
        #1;
        chk("idle_stall_gnt", 32'(bus1.data_gnt_o), 32'h0);
        cyc();
        stall1 = 1'b0;
        #1;
        chk("idle_stall_busy", 32'(busy1), 32'h0);

        // Store/load round trip at latency 1
        drv1(1'b1, 1'b1, 32'h0010_0010, 4'hF, 32'hDEAD_BEEF);
        #1;
        chk("st_gnt", 32'(bus1.data_gnt_o), 32'h1);
        chk("st_err", 32'(bus1.data_err_o), 32'h0);
        cyc();
        drv1(1'b1, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
        #1;
        chk("st_rvalid", 32'(bus1.data_rvalid_o), 32'h1);
        chk("st_rdata_zero", bus1.data_rdata_o, 32'h0);
        chk("ld_gnt_on_rvalid", 32'(bus1.data_gnt_o), 32'h1);
        chk("ld_err", 32'(bus1.data_err_o), 32'h0);
        cyc();
        drv1(1'b0, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
        #1;
        chk("ld_rvalid", 32'(bus1.data_rvalid_o), 32'h1);
        chk("ld_rdata", bus1.data_rdata_o, 32'hDEAD_BEEF);
        cyc();
        #1;
        chk("rt_rvalid_off", 32'(bus1.data_rvalid_o), 32'h0);
        chk("rt_busy_off", 32'(busy1), 32'h0);

        // Byte enables: 0x11223344 overwritten in lanes 1,2 by 0xAABBCCDD
        drv1(1'b1, 1'b1, 32'h0010_0020, 4'hF, 32'h1122_3344);
        cyc();
        drv1(1'b1, 1'b1, 32'h0010_0020, 4'b0110, 32'hAABB_CCDD);
        #1;
        chk("be_st_gnt", 32'(bus1.data_gnt_o), 32'h1);
        cyc();
        drv1(1'b1, 1'b0, 32'h0010_0020, 4'b0001, 32'h0);
        cyc();
        drv1(1'b0, 1'b0, 32'h0010_0020, 4'hF, 32'h0);
        #1;
        chk("be_rdata", bus1.data_rdata_o, 32'h11BB_CC44);
        cyc();

        // Byte enable 0000 is a no-op store
        drv1(1'b1, 1'b1, 32'h0010_0010, 4'b0000, 32'h0000_0000);
        cyc();
        drv1(1'b1, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
        cyc();
        drv1(1'b0, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
        #1;
        chk("be0_rdata", bus1.data_rdata_o, 32'hDEAD_BEEF);
        cyc();

        // Back-to-back: four stores then four loads with req held high
        for (int i = 0; i < 4; i++) begin
            drv1(1'b1, 1'b1, 32'h0010_0040 + 32'(4*i), 4'hF, 32'h0A0B_0C00 + 32'(i));
            #1;
            chk("b2b_st_gnt", 32'(bus1.data_gnt_o), 32'h1);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            drv1(1'b1, 1'b0, 32'h0010_0040 + 32'(4*i), 4'hF, 32'h0);
            #1;
            chk("b2b_ld_gnt", 32'(bus1.data_gnt_o), 32'h1);
            chk("b2b_rvalid", 32'(bus1.data_rvalid_o), 32'h1);
            chk("b2b_busy", 32'(busy1), 32'h1);
            if (i > 0) chk("b2b_rdata", bus1.data_rdata_o, 32'h0A0B_0C00 + 32'(i - 1));
            cyc();
        end
        drv1(1'b0, 1'b0, 32'h0010_0000, 4'hF, 32'h0);
        #1;
        chk("b2b_last_rvalid", 32'(bus1.data_rvalid_o), 32'h1);
        chk("b2b_last_rdata", bus1.data_rdata_o, 32'h0A0B_0C03);
        chk("b2b_last_busy", 32'(busy1), 32'h1);
        cyc();
        #1;
        chk("b2b_busy_off", 32'(busy1), 32'h0);

        // Range error: word 0 in range holds 0xCAFEF00D; aliasing address must not touch it
        drv1(1'b1, 1'b1, 32'h0010_0000, 4'hF, 32'hCAFE_F00D);
        cyc();
        drv1(1'b1, 1'b1, 32'h0020_0000, 4'hF, 32'h1234_5678);
        #1;
        chk("err_st_gnt", 32'(bus1.data_gnt_o), 32'h1);
        chk("err_st_err", 32'(bus1.data_err_o), 32'h1);
        cyc();
        drv1(1'b1, 1'b0, 32'h0020_0000, 4'hF, 32'h0);
        #1;
        chk("err_st_rvalid", 32'(bus1.data_rvalid_o), 32'h1);
        chk("err_ld_err", 32'(bus1.data_err_o), 32'h1);
        cyc();
        drv1(1'b1, 1'b0, 32'h0010_0000, 4'hF, 32'h0);
        #1;
        chk("err_ld_rvalid", 32'(bus1.data_rvalid_o), 32'h1);
        chk("err_ld_rdata", bus1.data_rdata_o, 32'h0);
        chk("ok_ld_err", 32'(bus1.data_err_o), 32'h0);
        cyc();
        drv1(1'b0, 1'b0, 32'h0010_0000, 4'hF, 32'h0);
        #1;
        chk("ram_unchanged", bus1.data_rdata_o, 32'hCAFE_F00D);
        cyc();

        // Latency 3 with stall: grant G0 = store
        drv3(1'b1, 1'b1, 32'h0010_0080, 4'hF, 32'h5566_7788);
        #1;
        chk("l3_g0_gnt", 32'(bus3.data_gnt_o), 32'h1);
        cyc();
        drv3(1'b1, 1'b0, 32'h0010_0080, 4'hF, 32'h0);
        #1;
        chk("l3_g1_gnt", 32'(bus3.data_gnt_o), 32'h0);
        chk("l3_g1_rvalid", 32'(bus3.data_rvalid_o), 32'h0);
        chk("l3_g1_busy", 32'(busy3), 32'h1);
        cyc();
        stall3 = 1'b1;
        #1;
        chk("l3_g2_gnt", 32'(bus3.data_gnt_o), 32'h0);
        chk("l3_g2_rvalid", 32'(bus3.data_rvalid_o), 32'h0);
        cyc();
        stall3 = 1'b0;
        #1;
        chk("l3_g3_rvalid", 32'(bus3.data_rvalid_o), 32'h1);
        chk("l3_g3_gnt", 32'(bus3.data_gnt_o), 32'h1);
        chk("l3_g3_rdata", bus3.data_rdata_o, 32'h0);
        cyc();
        cyc();
        cyc();
        // Load rvalid at G0+6; stall there must not hold back rvalid
        stall3 = 1'b1;
        #1;
        chk("l3_g6_rvalid", 32'(bus3.data_rvalid_o), 32'h1);
        chk("l3_g6_rdata", bus3.data_rdata_o, 32'h5566_7788);
        chk("l3_g6_gnt_stalled", 32'(bus3.data_gnt_o), 32'h0);
        cyc();
        stall3 = 1'b0;
        #1;
        chk("l3_g7_busy", 32'(busy3), 32'h0);
        chk("l3_g7_gnt", 32'(bus3.data_gnt_o), 32'h1);
        cyc();

        // Reset one cycle after a load grant: the load never responds
        rst = 1'b1;
        drv3(1'b0, 1'b0, 32'h0010_0080, 4'hF, 32'h0);
        #1;
        chk("rst_mid_gnt", 32'(bus3.data_gnt_o), 32'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy3), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_no_rvalid", 32'(bus3.data_rvalid_o), 32'h0);
            cyc();
        end
        drv3(1'b1, 1'b0, 32'h0010_0080, 4'hF, 32'h0);
        #1;
        chk("post_rst_gnt", 32'(bus3.data_gnt_o), 32'h1);
        cyc();
        drv3(1'b0, 1'b0, 32'h0010_0080, 4'hF, 32'h0);
        cyc();
        cyc();
        #1;
        chk("post_rst_rvalid", 32'(bus3.data_rvalid_o), 32'h1);
        chk("post_rst_rdata", bus3.data_rdata_o, 32'h5566_7788);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
